// File: rtl/ysyx_23060171_lsu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060171_lsu_pkg
// Shared types for the load/store unit:
//   lsu_state_e : FSM states (IDLE / REQ / WAIT / RESP)
//   lsu_size_e  : access size encoding carried on req_size
//   size_bytes  : number of bytes touched by an access of a given size
// ---------------------------------------------------------------------------
package ysyx_23060171_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/ysyx_23060171_lsu_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060171_lsu_if
// Bundles the three handshake channels around the LSU:
//   req_*      : EXU -> LSU request   (req_valid / req_ready)
//   resp_*     : LSU -> WBU result    (resp_valid / resp_ready)
//   mem_req_*  : LSU -> memory request, mem_addr/mem_wen/mem_wdata/mem_wstrb
//   mem_resp_* : memory -> LSU response, mem_rdata/mem_resp_err
// Handshake rule on every channel: a transfer happens in a cycle where both
// valid and ready are high at the rising clock edge; once valid is raised the
// sender keeps valid and its payload stable until that transfer.
// Modports:
//   master : the LSU itself (it masters the memory bus)
//   slave  : everything around it (EXU, WBU, memory)
// ---------------------------------------------------------------------------
interface ysyx_23060171_lsu_if #(
    parameter int XLEN = 32,
    parameter int AW   = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [AW-1:0]     req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;

    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [AW-1:0]     mem_addr;
    logic              mem_wen;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              mem_resp_valid;
    logic              mem_resp_ready;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_resp_err;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
        input  resp_ready, mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_resp_ready
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
        output resp_ready, mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_resp_ready
    );
endinterface

// File: rtl/ysyx_23060171_lsu_align.sv
// ---------------------------------------------------------------------------
// ysyx_23060171_lsu_align
// Purely combinational byte-lane logic.
//   i_off      : byte offset of the access inside the bus word
//   i_size     : access size (lsu_size_e encoding)
//   i_unsigned : zero-extend instead of sign-extend the load
//   i_wdata    : right-aligned store data
//   i_rdata    : raw aligned bus read word
//   o_wstrb    : byte strobes for the store
//   o_wdata    : store data moved into its byte lanes
//   o_rdata    : load data shifted down, truncated and extended
// ---------------------------------------------------------------------------
module ysyx_23060171_lsu_align
    import ysyx_23060171_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] i_off,
    input  logic [1:0]                i_size,
    input  logic                      i_unsigned,
    input  logic [XLEN-1:0]           i_wdata,
    input  logic [XLEN-1:0]           i_rdata,
    output logic [XLEN/8-1:0]         o_wstrb,
    output logic [XLEN-1:0]           o_wdata,
    output logic [XLEN-1:0]           o_rdata
);
    localparam int NB = XLEN / 8;

    logic [NB-1:0]   w_base;
    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_mask;
    logic            w_sign;

    // 2^bytes - 1 gives the strobe pattern of the access at lane 0.
    assign w_base  = NB'((9'd1 << size_bytes(i_size)) - 9'd1);
    assign o_wstrb = w_base << i_off;
    assign o_wdata = i_wdata << {i_off, 3'b000};

    assign w_sh = i_rdata >> {i_off, 3'b000};

    // w_mask keeps the loaded bits; a full-width access keeps everything,
    // so ~w_mask is zero and i_unsigned has no effect there.
    always_comb begin
        w_mask = '1;
        w_sign = 1'b0;
        case (lsu_size_e'(i_size))
            SZ_B: begin
                w_mask = XLEN'(64'h0000_0000_0000_00FF);
                w_sign = w_sh[7];
            end
            SZ_H: begin
                w_mask = XLEN'(64'h0000_0000_0000_FFFF);
                w_sign = w_sh[15];
            end
            SZ_W: begin
                w_mask = XLEN'(64'h0000_0000_FFFF_FFFF);
                w_sign = w_sh[31];
            end
            default: begin
                w_mask = '1;
                w_sign = 1'b0;
            end
        endcase
    end

    assign o_rdata = (w_sh & w_mask) | ({XLEN{w_sign & ~i_unsigned}} & ~w_mask);

endmodule

// File: rtl/ysyx_23060171_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_23060171_lsu
// Multi-cycle load/store unit between EXU (request) and WBU (response),
// driving a valid/ready data bus with one transaction in flight.
//   clk, rst     : clock, synchronous active-high reset
//   io_bus       : master modport of ysyx_23060171_lsu_if (req/resp/mem)
//   o_dbg_state  : current FSM state
// Parameters: XLEN (32 or 64), AW, TIMEOUT_CYCLES.
// Build option: define LSU_TIMEOUT_EN to add a WAIT-state watchdog that
// ends a transaction with resp_err=1 after TIMEOUT_CYCLES silent cycles.
// Without it the LSU waits for the bus indefinitely.
// ---------------------------------------------------------------------------
module ysyx_23060171_lsu
    import ysyx_23060171_lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_23060171_lsu_if.master        io_bus,
    output lsu_state_e                 o_dbg_state
);
    localparam int OFFW = $clog2(XLEN / 8);

    lsu_state_e        r_state;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_mem_req_valid;
    logic              r_mem_resp_ready;
    logic              r_wen;
    logic              r_unsigned;
    logic [AW-1:0]     r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [1:0]        r_size;
    logic [XLEN-1:0]   r_rdata;
    logic              r_err;

    logic [2:0]        w_lowmask;
    logic              w_misalign;
    logic              w_illegal;
    logic              w_accept;
    logic [XLEN/8-1:0] w_wstrb;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_rdata_ext;

    // Misaligned means any address bit below the access size is set.
    assign w_lowmask  = 3'(size_bytes(io_bus.req_size) - 4'd1);
    assign w_misalign = |(io_bus.req_addr[2:0] & w_lowmask);
    assign w_illegal  = (io_bus.req_size == SZ_D) && (XLEN < 64);
    assign w_accept   = io_bus.req_valid && r_req_ready;

    ysyx_23060171_lsu_align #(.XLEN(XLEN)) u_align (
        .i_off      (r_addr[OFFW-1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdata    (io_bus.mem_rdata),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata_ext)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int TOW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);
    logic [TOW-1:0] r_to_cnt;
`else
    // The watchdog limit only matters when the watchdog is built in.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_req_ready      <= 1'b1;
            r_resp_valid     <= 1'b0;
            r_mem_req_valid  <= 1'b0;
            r_mem_resp_ready <= 1'b0;
            r_wen            <= 1'b0;
            r_unsigned       <= 1'b0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_size           <= '0;
            r_rdata          <= '0;
            r_err            <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_to_cnt         <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_wen       <= io_bus.req_wen;
                        r_unsigned  <= io_bus.req_unsigned;
                        r_addr      <= io_bus.req_addr;
                        r_wdata     <= io_bus.req_wdata;
                        r_size      <= io_bus.req_size;
                        r_rdata     <= '0;
                        r_req_ready <= 1'b0;
                        if (w_misalign || w_illegal) begin
                            // Rejected without touching the bus.
                            r_err        <= 1'b1;
                            r_resp_valid <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            r_err           <= 1'b0;
                            r_mem_req_valid <= 1'b1;
                            r_state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (io_bus.mem_req_ready) begin
                        r_mem_req_valid  <= 1'b0;
                        r_mem_resp_ready <= 1'b1;
                        r_state          <= WAIT;
`ifdef LSU_TIMEOUT_EN
                        r_to_cnt         <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (io_bus.mem_resp_valid) begin
                        r_rdata          <= r_wen ? '0 : w_rdata_ext;
                        r_err            <= io_bus.mem_resp_err;
                        r_mem_resp_ready <= 1'b0;
                        r_resp_valid     <= 1'b1;
                        r_state          <= RESP;
                    end
`ifdef LSU_TIMEOUT_EN
                    // Counter is 0 in the first WAIT cycle, so seeing
                    // TIMEOUT_CYCLES-1 here means this is the last allowed
                    // silent cycle.
                    else if (r_to_cnt == TO_LAST) begin
                        r_rdata          <= '0;
                        r_err            <= 1'b1;
                        r_mem_resp_ready <= 1'b0;
                        r_resp_valid     <= 1'b1;
                        r_state          <= RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    // req_ready rises only after the handshake edge, so a
                    // new request is never taken in the handshake cycle.
                    if (io_bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.req_ready      = r_req_ready;
    assign io_bus.resp_valid     = r_resp_valid;
    assign io_bus.resp_rdata     = r_rdata;
    assign io_bus.resp_err       = r_err;
    assign io_bus.mem_req_valid  = r_mem_req_valid;
    assign io_bus.mem_addr       = {r_addr[AW-1:OFFW], {OFFW{1'b0}}};
    assign io_bus.mem_wen        = r_wen;
    assign io_bus.mem_wdata      = w_wdata;
    assign io_bus.mem_wstrb      = w_wstrb;
    assign io_bus.mem_resp_ready = r_mem_resp_ready;
    assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_ysyx_23060171_lsu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060171_lsu
// Drives a 32-bit and a 64-bit LSU from one set of stimulus variables; sel64
// picks which one is active while the other sees idle inputs.
// ---------------------------------------------------------------------------
module tb_ysyx_23060171_lsu;
    import ysyx_23060171_lsu_pkg::*;

    localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic t_rst;
    logic sel64;
    int   n_checks;
    int   n_errors;
    int   cyc;

    logic        t_req_valid, t_wen, t_uns, t_resp_ready;
    logic [31:0] t_addr;
    logic [63:0] t_wdata;
    logic [1:0]  t_size;
    logic        t_mem_req_ready, t_mem_resp_valid, t_mem_resp_err;
    logic [63:0] t_mem_rdata;

    ysyx_23060171_lsu_if #(.XLEN(32), .AW(32)) b32 ();
    ysyx_23060171_lsu_if #(.XLEN(64), .AW(32)) b64 ();
    lsu_state_e st32, st64;

    ysyx_23060171_lsu #(.XLEN(32), .AW(32), .TIMEOUT_CYCLES(TO)) u_dut32 (
        .clk(clk), .rst(t_rst), .io_bus(b32), .o_dbg_state(st32));
    ysyx_23060171_lsu #(.XLEN(64), .AW(32), .TIMEOUT_CYCLES(TO)) u_dut64 (
        .clk(clk), .rst(t_rst), .io_bus(b64), .o_dbg_state(st64));

    assign b32.req_valid      = t_req_valid & ~sel64;
    assign b32.req_wen        = t_wen;
    assign b32.req_addr       = t_addr;
    assign b32.req_wdata      = t_wdata[31:0];
    assign b32.req_size       = t_size;
    assign b32.req_unsigned   = t_uns;
    assign b32.resp_ready     = t_resp_ready & ~sel64;
    assign b32.mem_req_ready  = t_mem_req_ready & ~sel64;
    assign b32.mem_resp_valid = t_mem_resp_valid & ~sel64;
    assign b32.mem_rdata      = t_mem_rdata[31:0];
    assign b32.mem_resp_err   = t_mem_resp_err;

    assign b64.req_valid      = t_req_valid & sel64;
    assign b64.req_wen        = t_wen;
    assign b64.req_addr       = t_addr;
    assign b64.req_wdata      = t_wdata;
    assign b64.req_size       = t_size;
    assign b64.req_unsigned   = t_uns;
    assign b64.resp_ready     = t_resp_ready & sel64;
    assign b64.mem_req_ready  = t_mem_req_ready & sel64;
    assign b64.mem_resp_valid = t_mem_resp_valid & sel64;
    assign b64.mem_rdata      = t_mem_rdata;
    assign b64.mem_resp_err   = t_mem_resp_err;

    wire        o_req_ready      = sel64 ? b64.req_ready      : b32.req_ready;
    wire        o_resp_valid     = sel64 ? b64.resp_valid     : b32.resp_valid;
    wire        o_resp_err       = sel64 ? b64.resp_err       : b32.resp_err;
    wire [63:0] o_resp_rdata     = sel64 ? b64.resp_rdata     : {32'h0, b32.resp_rdata};
    wire        o_mem_req_valid  = sel64 ? b64.mem_req_valid  : b32.mem_req_valid;
    wire [31:0] o_mem_addr       = sel64 ? b64.mem_addr       : b32.mem_addr;
    wire        o_mem_wen        = sel64 ? b64.mem_wen        : b32.mem_wen;
    wire [63:0] o_mem_wdata      = sel64 ? b64.mem_wdata      : {32'h0, b32.mem_wdata};
    wire [7:0]  o_mem_wstrb      = sel64 ? b64.mem_wstrb      : {4'h0, b32.mem_wstrb};
    wire        o_mem_resp_ready = sel64 ? b64.mem_resp_ready : b32.mem_resp_ready;
    wire [1:0]  o_state          = sel64 ? st64 : st32;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"},      64'(o_req_ready), 64'd1);
        chk({tag, "_resp_valid"},     64'(o_resp_valid), 64'd0);
        chk({tag, "_resp_err"},       64'(o_resp_err), 64'd0);
        chk({tag, "_resp_rdata"},     o_resp_rdata, 64'd0);
        chk({tag, "_mem_req_valid"},  64'(o_mem_req_valid), 64'd0);
        chk({tag, "_mem_resp_ready"}, 64'(o_mem_resp_ready), 64'd0);
        chk({tag, "_mem_addr"},       64'(o_mem_addr), 64'd0);
        chk({tag, "_state"},          64'(o_state), 64'(IDLE));
    endtask

    // Reference: byte-lane arithmetic straight from the access rules.
    function automatic void model(
        input  bit          s64,
        input  logic [31:0] addr,
        input  logic [63:0] wdata,
        input  logic [1:0]  size,
        input  bit          uns,
        input  logic [63:0] rdata,
        output bit          short_err,
        output logic [31:0] e_addr,
        output logic [7:0]  e_wstrb,
        output logic [63:0] e_wdata,
        output logic [63:0] e_load
    );
        int nb, sz, off, bits;
        logic [63:0] xmask, v, m;
        nb        = s64 ? 8 : 4;
        sz        = 1 << size;
        off       = int'(addr % nb);
        xmask     = s64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        short_err = ((addr % sz) != 0) || (sz > nb);
        e_addr    = addr - 32'(off);
        e_wstrb   = 8'(((1 << sz) - 1) << off);
        e_wdata   = (wdata << (8 * off)) & xmask;
        v         = (rdata & xmask) >> (8 * off);
        bits      = 8 * sz;
        m         = (bits >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
        v         = v & m;
        if (!uns && (bits < nb * 8) && v[bits-1]) v = v | ~m;
        e_load    = v & xmask;
    endfunction

    // One full transaction with the given bus/WBU delays.
    task automatic run_txn(
        input bit          s64,
        input bit          wen,
        input logic [31:0] addr,
        input logic [63:0] wdata,
        input logic [1:0]  size,
        input bit          uns,
        input int          rq_d,
        input int          rsp_d,
        input logic [63:0] rdata,
        input bit          berr,
        input int          rr_d
    );
        bit          short_err, timed_out;
        logic [31:0] e_addr;
        logic [7:0]  e_wstrb;
        logic [63:0] e_wdata, e_load, e_rdata;
        bit          e_err;
        int          w, e_lat;
        model(s64, addr, wdata, size, uns, rdata, short_err, e_addr, e_wstrb, e_wdata, e_load);
        timed_out = TO_EN && !short_err && (rsp_d >= TO);
        w         = timed_out ? TO : rsp_d + 1;
        e_err     = short_err || timed_out || berr;
        e_rdata   = (short_err || timed_out || wen) ? 64'd0 : e_load;
        e_lat     = short_err ? 1 : 1 + (rq_d + 1) + w;

        sel64 = s64;
        #1;
        chk("idle_req_ready", 64'(o_req_ready), 64'd1);
        chk("idle_resp_valid", 64'(o_resp_valid), 64'd0);
        t_req_valid = 1'b1; t_wen = wen; t_addr = addr; t_wdata = wdata;
        t_size = size; t_uns = uns;
        cyc = 0;
        step();
        // Scramble request fields: the LSU must work from its captured copy.
        t_req_valid = 1'b0; t_wen = 1'($urandom); t_addr = $urandom;
        t_wdata = {$urandom, $urandom}; t_size = 2'($urandom); t_uns = 1'($urandom);

        if (!short_err) begin
            for (int k = 0; k <= rq_d; k++) begin
                chk("mem_req_valid", 64'(o_mem_req_valid), 64'd1);
                chk("mem_addr", 64'(o_mem_addr), 64'(e_addr));
                chk("mem_wen", 64'(o_mem_wen), 64'(wen));
                chk("mem_wdata", o_mem_wdata, e_wdata);
                chk("mem_wstrb", 64'(o_mem_wstrb), 64'(e_wstrb));
                chk("req_ready_busy", 64'(o_req_ready), 64'd0);
                chk("req_resp_valid", 64'(o_resp_valid), 64'd0);
                chk("req_mem_resp_ready", 64'(o_mem_resp_ready), 64'd0);
                t_mem_req_ready = (k == rq_d);
                step();
            end
            t_mem_req_ready = 1'b0;
            for (int k = 0; k < w; k++) begin
                chk("wait_mem_resp_ready", 64'(o_mem_resp_ready), 64'd1);
                chk("wait_mem_req_valid", 64'(o_mem_req_valid), 64'd0);
                chk("wait_resp_valid", 64'(o_resp_valid), 64'd0);
                t_mem_resp_valid = (k == rsp_d);
                t_mem_rdata      = (k == rsp_d) ? rdata : {$urandom, $urandom};
                t_mem_resp_err   = (k == rsp_d) ? berr : 1'($urandom);
                step();
            end
            t_mem_resp_valid = 1'b0;
        end

        chk("latency", 64'(cyc), 64'(e_lat));
        for (int k = 0; k <= rr_d; k++) begin
            chk("resp_valid", 64'(o_resp_valid), 64'd1);
            chk("resp_rdata", o_resp_rdata, e_rdata);
            chk("resp_err", 64'(o_resp_err), 64'(e_err));
            chk("resp_req_ready", 64'(o_req_ready), 64'd0);
            chk("resp_mem_req_valid", 64'(o_mem_req_valid), 64'd0);
            chk("resp_mem_resp_ready", 64'(o_mem_resp_ready), 64'd0);
            t_resp_ready     = (k == rr_d);
            t_mem_resp_valid = timed_out;   // late stray response
            t_mem_rdata      = {$urandom, $urandom};
            step();
        end
        t_resp_ready = 1'b0;
        t_mem_resp_valid = 1'b0;
        chk("post_resp_valid", 64'(o_resp_valid), 64'd0);
        chk("post_req_ready", 64'(o_req_ready), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          sz;
        logic [31:0] a;
        n_checks = 0; n_errors = 0; cyc = 0;
        sel64 = 1'b0; t_rst = 1'b1;
        t_req_valid = 1'b0; t_wen = 1'b0; t_uns = 1'b0; t_resp_ready = 1'b0;
        t_addr = '0; t_wdata = '0; t_size = '0;
        t_mem_req_ready = 1'b0; t_mem_resp_valid = 1'b0; t_mem_resp_err = 1'b0;
        t_mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        t_rst = 1'b0;
        sel64 = 1'b0; #1; check_reset_vals("rst32");
        sel64 = 1'b1; #1; check_reset_vals("rst64");

        // Store byte at lane 3.
        run_txn(0, 1, 32'h8000_0003, 64'h0000_00AB, 2'd0, 0, 0, 0, 64'h0, 0, 0);
        // Signed and unsigned half loads.
        run_txn(0, 0, 32'h8000_0002, 64'h0, 2'd1, 0, 0, 0, 64'h8234_5678, 0, 0);
        run_txn(0, 0, 32'h8000_0002, 64'h0, 2'd1, 1, 0, 0, 64'h8234_5678, 0, 0);
        // Misaligned word and illegal double on XLEN=32.
        run_txn(0, 0, 32'h8000_0001, 64'h0, 2'd2, 0, 0, 0, 64'h0, 0, 0);
        run_txn(0, 0, 32'h8000_0000, 64'h0, 2'd3, 0, 0, 0, 64'h0, 0, 0);
        // XLEN=64 signed word from the upper half, then a full double.
        run_txn(1, 0, 32'h8000_0004, 64'h0, 2'd2, 0, 0, 0, 64'h9000_0000_1234_5678, 0, 0);
        run_txn(1, 0, 32'h8000_0008, 64'h0, 2'd3, 1, 0, 0, 64'h8765_4321_0FED_CBA9, 0, 0);
        run_txn(1, 1, 32'h8000_0006, 64'hBEEF, 2'd1, 0, 0, 0, 64'h0, 0, 0);
        // Backpressure on both sides.
        run_txn(0, 0, 32'h8000_0004, 64'h0, 2'd2, 0, 5, 1, 64'hCAFE_F00D, 0, 3);
        // Bus error on a store.
        run_txn(0, 1, 32'h8000_0008, 64'h1234_5678, 2'd2, 0, 0, 0, 64'h0, 1, 0);
        // Long silent bus: completes normally, or times out with the watchdog.
        run_txn(0, 0, 32'h8000_000C, 64'h0, 2'd2, 0, 0, 10, 64'h7654_3210, 0, 0);

        // Reset while waiting on the bus.
        sel64 = 1'b0;
        t_req_valid = 1'b1; t_wen = 1'b0; t_addr = 32'h8000_0010; t_size = 2'd2; t_uns = 1'b0;
        step();
        t_req_valid = 1'b0; t_mem_req_ready = 1'b1;
        step();
        t_mem_req_ready = 1'b0;
        chk("pre_rst_wait", 64'(o_mem_resp_ready), 64'd1);
        t_rst = 1'b1;
        step();
        t_rst = 1'b0;
        check_reset_vals("rst_wait");

        // Randomized traffic on both widths.
        for (int i = 0; i < 150; i++) begin
            t_size = 2'($urandom_range(0, 3));
            sz = 1 << t_size;
            a = 32'h8000_0000 | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
            run_txn(1'($urandom), 1'($urandom), a, {$urandom, $urandom}, 2'(t_size),
                    1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    {$urandom, $urandom}, ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
